// File: rtl/control_volcado_mem_datos_pkg.sv
// Shared definitions for the data-memory dump controller: address-width helper,
// FSM state encoding and default memory geometry.
package control_volcado_mem_datos_pkg;

  localparam int unsigned RAM_DEPTH_DEF = 1024;
  localparam int unsigned RAM_WIDTH_DEF = 32;

  typedef logic [2:0] estado_t;

  localparam estado_t IDLE  = 3'd0;
  localparam estado_t CHECK = 3'd1;
  localparam estado_t READ  = 3'd2;
  localparam estado_t LATCH = 3'd3;
  localparam estado_t SEND  = 3'd4;
  localparam estado_t DONE  = 3'd5;

  // Bits needed to address 'depth' words; never less than one.
  function automatic int unsigned clogb2(input int unsigned depth);
    int unsigned res;
    int unsigned val;
    res = 0;
    val = (depth > 0) ? depth - 1 : 0;
    while (val > 0) begin
      res = res + 1;
      val = val >> 1;
    end
    return (res == 0) ? 1 : res;
  endfunction

endpackage

// File: rtl/control_volcado_mem_datos_if.sv
// Dump channel between the dump controller (master) and the debug unit (slave):
// start request, valid/ready word stream, end-of-walk pulse and busy flag.
interface control_volcado_mem_datos_if #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned RAM_WIDTH = 32
);

  logic                 dump_start;
  logic                 dump_ready;
  logic                 dump_valid;
  logic [ADDR_W-1:0]    dump_addr;
  logic [RAM_WIDTH-1:0] dump_data;
  logic                 dump_done;
  logic                 busy;

  modport master (
    input  dump_start,
    input  dump_ready,
    output dump_valid,
    output dump_addr,
    output dump_data,
    output dump_done,
    output busy
  );

  modport slave (
    output dump_start,
    output dump_ready,
    input  dump_valid,
    input  dump_addr,
    input  dump_data,
    input  dump_done,
    input  busy
  );

endinterface

// File: rtl/contador_direccion_volcado.sv
// Address counter for the dump walk: synchronous clear, increment and a flag
// that marks the last memory address.
module contador_direccion_volcado
  import control_volcado_mem_datos_pkg::*;
#(
  parameter int unsigned RAM_DEPTH = RAM_DEPTH_DEF,
  parameter int unsigned ADDR_W    = clogb2(RAM_DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_soft_reset,
  input  logic              i_clear,
  input  logic              i_incr,
  output logic [ADDR_W-1:0] o_cuenta,
  output logic              o_ultima
);

  localparam logic [ADDR_W-1:0] ULTIMA_DIR = ADDR_W'(RAM_DEPTH - 1);

  logic [ADDR_W-1:0] cuenta_q;
  logic [ADDR_W-1:0] cuenta_d;

  always_comb begin
    cuenta_d = cuenta_q;
    if (i_clear) begin
      cuenta_d = '0;
    end else if (i_incr) begin
      cuenta_d = cuenta_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_soft_reset) begin
    if (!i_soft_reset) begin
      cuenta_q <= '0;
    end else begin
      cuenta_q <= cuenta_d;
    end
  end

  assign o_cuenta = cuenta_q;
  assign o_ultima = (cuenta_q == ULTIMA_DIR);

endmodule

// File: rtl/control_volcado_mem_datos.sv
// Data-memory port arbiter: passes MEM-stage accesses through while idle and, on request,
// walks the memory streaming dirty words to the debug unit. DUMP_ALL_EN sends every word.
module control_volcado_mem_datos
  import control_volcado_mem_datos_pkg::*;
#(
  parameter int unsigned RAM_DEPTH = RAM_DEPTH_DEF,
  parameter int unsigned RAM_WIDTH = RAM_WIDTH_DEF,
  localparam int unsigned ADDR_W   = clogb2(RAM_DEPTH)
) (
  input  logic                        i_clk,
  input  logic                        i_soft_reset,
  // MEM stage
  input  logic [ADDR_W-1:0]           i_mem_addr,
  input  logic                        i_mem_ena,
  input  logic                        i_mem_wea,
  input  logic [RAM_WIDTH-1:0]        i_mem_data,
  output logic                        o_stall,
  // Debug unit
  control_volcado_mem_datos_if.master dump,
  // Data memory and dirty-bit tracker
  output logic [ADDR_W-1:0]           o_ram_addr,
  output logic                        o_ram_ena,
  output logic                        o_ram_wea,
  output logic [RAM_WIDTH-1:0]        o_ram_data,
  input  logic [RAM_WIDTH-1:0]        i_ram_data,
  input  logic                        i_bit_sucio
);

  estado_t              estado_q;
  estado_t              estado_d;
  logic [ADDR_W-1:0]    dump_addr_q;
  logic [ADDR_W-1:0]    dump_addr_d;
  logic [RAM_WIDTH-1:0] dump_data_q;
  logic [RAM_WIDTH-1:0] dump_data_d;

  logic [ADDR_W-1:0]    contador;
  logic                 cnt_clear;
  logic                 cnt_incr;
  logic                 cnt_ultima;
  logic                 sucio;

  logic                 dump_valid;
  logic                 dump_done;
  logic                 ocupado;

`ifdef DUMP_ALL_EN
  logic unused_bit_sucio;
  assign unused_bit_sucio = i_bit_sucio;
  assign sucio            = 1'b1;
`else
  assign sucio            = i_bit_sucio;
`endif

  contador_direccion_volcado #(
    .RAM_DEPTH (RAM_DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_contador (
    .i_clk        (i_clk),
    .i_soft_reset (i_soft_reset),
    .i_clear      (cnt_clear),
    .i_incr       (cnt_incr),
    .o_cuenta     (contador),
    .o_ultima     (cnt_ultima)
  );

  always_ff @(posedge i_clk or negedge i_soft_reset) begin
    if (!i_soft_reset) begin
      estado_q    <= IDLE;
      dump_addr_q <= '0;
      dump_data_q <= '0;
    end else begin
      estado_q    <= estado_d;
      dump_addr_q <= dump_addr_d;
      dump_data_q <= dump_data_d;
    end
  end

  // Next state, counter control and the captured word.
  always_comb begin
    estado_d    = estado_q;
    cnt_clear   = 1'b0;
    cnt_incr    = 1'b0;
    dump_addr_d = dump_addr_q;
    dump_data_d = dump_data_q;
    case (estado_q)
      IDLE: begin
        if (dump.dump_start) begin
          cnt_clear = 1'b1;
          estado_d  = CHECK;
        end
      end
      CHECK: begin
        if (sucio) begin
          estado_d = READ;
        end else if (cnt_ultima) begin
          estado_d = DONE;
        end else begin
          cnt_incr = 1'b1;
        end
      end
      READ:  estado_d = LATCH;
      LATCH: begin
        dump_addr_d = contador;
        dump_data_d = i_ram_data;
        estado_d    = SEND;
      end
      SEND: begin
        if (dump.dump_ready) begin
          if (cnt_ultima) begin
            estado_d = DONE;
          end else begin
            cnt_incr = 1'b1;
            estado_d = CHECK;
          end
        end
      end
      DONE:    estado_d = IDLE;
      default: estado_d = IDLE;
    endcase
  end

  // Outputs: the port belongs to the MEM stage only in IDLE.
  always_comb begin
    ocupado    = 1'b1;
    dump_valid = 1'b0;
    dump_done  = 1'b0;
    o_ram_addr = contador;
    o_ram_ena  = 1'b0;
    o_ram_wea  = 1'b0;
    o_ram_data = '0;
    case (estado_q)
      IDLE: begin
        ocupado    = 1'b0;
        o_ram_addr = i_mem_addr;
        o_ram_ena  = i_mem_ena;
        o_ram_wea  = i_mem_wea;
        o_ram_data = i_mem_data;
      end
      READ:    o_ram_ena  = 1'b1;
      SEND:    dump_valid = 1'b1;
      DONE:    dump_done  = 1'b1;
      default: ;
    endcase
  end

  assign o_stall         = ocupado;
  assign dump.busy       = ocupado;
  assign dump.dump_valid = dump_valid;
  assign dump.dump_done  = dump_done;
  assign dump.dump_addr  = dump_addr_q;
  assign dump.dump_data  = dump_data_q;

endmodule

// File: doc/control_volcado_mem_datos.md
# control_volcado_mem_datos

Controller and arbiter for the data-memory port and its dirty-bit tracker. While idle it passes MEM-stage accesses straight through. On a start request from the debug unit it takes the port, walks every address, reads each dirty word, and streams the address/data pairs to the debug unit over a valid/ready handshake. It sits between the MEM stage, the debug unit, and the data memory with its dirty-bit tracker; the memory address bus also drives the tracker address.

## Interface
- RAM_DEPTH, 1024, number of data-memory words; address width ADDR_W = clogb2(RAM_DEPTH)
- RAM_WIDTH, 32, data word width
- i_clk  in  1  clock; all state changes on its rising edge
- i_soft_reset  in  1  asynchronous, active-low reset
- i_mem_addr  in  ADDR_W  MEM-stage address
- i_mem_ena  in  1  MEM-stage enable
- i_mem_wea  in  1  MEM-stage write enable
- i_mem_data  in  RAM_WIDTH  MEM-stage write data
- o_stall  out  1  MEM stage must hold its access (port busy)
- i_dump_start  in  1  debug unit requests a dump; sampled in IDLE only
- i_dump_ready  in  1  debug unit accepts the current word
- o_dump_valid  out  1  o_dump_addr and o_dump_data are valid
- o_dump_addr  out  ADDR_W  address of the word being sent
- o_dump_data  out  RAM_WIDTH  word being sent
- o_dump_done  out  1  one-cycle pulse at the end of the walk
- o_busy  out  1  high in every state except IDLE
- o_ram_addr  out  ADDR_W  memory and tracker address
- o_ram_ena  out  1  memory enable
- o_ram_wea  out  1  memory write enable; also feeds the tracker
- o_ram_data  out  RAM_WIDTH  memory write data
- i_ram_data  in  RAM_WIDTH  memory read data; synchronous read, valid the cycle after ena
- i_bit_sucio  in  1  tracker dirty bit for o_ram_addr; combinational

## Operation
- States: IDLE, CHECK, READ, LATCH, SEND, DONE.
- IDLE:
  - o_ram_* is a combinational copy of i_mem_*; o_stall = 0.
  - i_dump_start = 1: address counter ← 0, next state CHECK.
- CHECK:
  - o_ram_addr = counter, o_ram_ena = 0, o_ram_wea = 0.
  - i_bit_sucio = 1 → READ.
  - Otherwise, if counter = RAM_DEPTH-1 → DONE; else counter+1, stay in CHECK.
- READ: o_ram_addr = counter, o_ram_ena = 1, o_ram_wea = 0 → LATCH.
- LATCH: o_dump_data ← i_ram_data and o_dump_addr ← counter are registered → SEND.
- SEND:
  - o_dump_valid = 1; data and address stay stable until the handshake.
  - On i_dump_ready = 1: if counter = RAM_DEPTH-1 → DONE; else counter+1 → CHECK.
- DONE: o_dump_done = 1 for one cycle → IDLE.
- In every state except IDLE: o_stall = 1, o_ram_wea = 0 and i_mem_* is ignored. Writes are never issued during a dump, so the tracker never changes during a dump.
- Counter width is ADDR_W and it never wraps; the last address is detected by comparing with RAM_DEPTH-1.

## Timing
- Reset values:
  - State = IDLE, counter = 0.
  - o_dump_valid, o_dump_done, o_busy and o_stall = 0; o_dump_addr and o_dump_data = 0.
  - o_ram_* outputs follow the pass-through of i_mem_*.
- Start latency: i_dump_start high in cycle N → o_busy and o_stall high from cycle N+1.
- Clean word: 1 cycle. Dirty word: 3 cycles, then SEND; with i_dump_ready tied high, o_dump_valid rises 3 cycles after CHECK is entered and lasts 1 cycle.
- A MEM access and i_dump_start in the same IDLE cycle: the access completes that cycle and CHECK begins the next cycle.
- i_dump_start outside IDLE is ignored; no queuing.
- i_dump_ready while o_dump_valid = 0 has no effect.
- Reset asserted mid-dump: immediate return to IDLE with reset values on all outputs; no o_dump_done pulse.

## Configuration
- DUMP_ALL_EN defined: CHECK ignores i_bit_sucio and every address is read and sent, RAM_DEPTH words per dump.
- DUMP_ALL_EN undefined: only dirty words are sent; clean words cost 1 cycle each.

## Structure
- Shared package holds:
  - the clogb2 function;
  - the state encoding localparams (IDLE=0, CHECK=1, READ=2, LATCH=3, SEND=4, DONE=5, 3 bits);
  - default RAM_DEPTH and RAM_WIDTH.
- One natural sub-module: contador_direccion_volcado, the address counter with clear, increment and last-address flag.

## Test plan
- Reset, then MEM write addr 5 data 0xDEADBEEF in IDLE → o_ram_* mirrors the write in the same cycle; o_stall = 0.
- Tracker dirty at addresses {3, 1023}, RAM_DEPTH = 1024, i_dump_ready tied 1 → exactly two handshakes: (3, data3) then (1023, data1023); o_dump_done pulses once; 1024 + 2·3 + 2 cycles from start to done.
- Tracker dirty at addr 7, i_dump_ready held 0 for 10 cycles → o_dump_valid high for 10+ cycles with o_dump_addr = 7 and data stable; advance only on ready.
- i_dump_start asserted while SEND is pending → ignored; the walk completes once with no second dump.
- Reset pulled low in SEND at addr 12 → next cycle o_busy = 0, o_dump_valid = 0, no o_dump_done; a fresh start walks from address 0.
- DUMP_ALL_EN defined, tracker all clean, RAM_DEPTH = 16 → 16 handshakes with addresses 0..15 in order.
